// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch squash and
// saturating stall/flush event counters.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rd1,
  input  logic [WIDTH-1:0] id_rd2,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [RADDR-1:0] id_rs,
  input  logic [RADDR-1:0] id_rt,
  input  logic [RADDR-1:0] id_rd,
  input  logic             id_uses_rt,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic [3:0]       id_alu_op,
  input  logic             flush,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_rd1,
  output logic [WIDTH-1:0] ex_rd2,
  output logic [WIDTH-1:0] ex_imm,
  output logic [RADDR-1:0] ex_rs,
  output logic [RADDR-1:0] ex_rt,
  output logic [RADDR-1:0] ex_wreg,
  output logic             ex_alu_src,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic [3:0]       ex_alu_op,
  output logic             stall,
  output logic [CNTW-1:0]  stall_cnt,
  output logic [CNTW-1:0]  flush_cnt
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [RADDR-1:0] rs;
    logic [RADDR-1:0] rt;
    logic [RADDR-1:0] wreg;
    logic             alu_src;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic [3:0]       alu_op;
  } ex_t;

  ex_t              ex_reg;
  ex_t              ex_next;
  logic [RADDR-1:0] wreg_next;
  logic             hz;
  logic [1:0]       cnt_evt;
  logic [CNTW-1:0]  cnt_reg [2];

  always_comb begin
    wreg_next = id_reg_dst ? id_rd : id_rt;
    hz = id_valid && ex_reg.valid && ex_reg.mem_read && (ex_reg.wreg != '0) &&
         ((ex_reg.wreg == id_rs) || (id_uses_rt && (ex_reg.wreg == id_rt)));
  end

  // A flush discards the dependent instruction, so it never needs to wait.
  assign stall = hz & ~flush;

  // Any bubble (flush, hazard, empty ID) is an all-zero NOP.
  always_comb begin
    ex_next = '0;
    if (!(flush || hz || !id_valid)) begin
      ex_next.valid      = 1'b1;
      ex_next.rd1        = id_rd1;
      ex_next.rd2        = id_rd2;
      ex_next.imm        = id_imm;
      ex_next.rs         = id_rs;
      ex_next.rt         = id_rt;
      ex_next.wreg       = wreg_next;
      ex_next.alu_src    = id_alu_src;
      ex_next.reg_write  = id_reg_write && (wreg_next != '0);
      ex_next.mem_read   = id_mem_read;
      ex_next.mem_write  = id_mem_write;
      ex_next.mem_to_reg = id_mem_to_reg;
      ex_next.alu_op     = id_alu_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ex_reg <= '0;
    else        ex_reg <= ex_next;
  end

  // Index 0 counts stalls, index 1 counts squashed real instructions.
  assign cnt_evt = {flush & id_valid, stall};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n)
        cnt_reg[i] <= '0;
      else if (cnt_evt[i] && (cnt_reg[i] != '1))
        cnt_reg[i] <= cnt_reg[i] + CNTW'(1);
    end
  end

  assign ex_valid      = ex_reg.valid;
  assign ex_rd1        = ex_reg.rd1;
  assign ex_rd2        = ex_reg.rd2;
  assign ex_imm        = ex_reg.imm;
  assign ex_rs         = ex_reg.rs;
  assign ex_rt         = ex_reg.rt;
  assign ex_wreg       = ex_reg.wreg;
  assign ex_alu_src    = ex_reg.alu_src;
  assign ex_reg_write  = ex_reg.reg_write;
  assign ex_mem_read   = ex_reg.mem_read;
  assign ex_mem_write  = ex_reg.mem_write;
  assign ex_mem_to_reg = ex_reg.mem_to_reg;
  assign ex_alu_op     = ex_reg.alu_op;
  assign stall_cnt     = cnt_reg[0];
  assign flush_cnt     = cnt_reg[1];

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a default instance plus a CNTW=4 instance
// sharing the same stimulus to exercise counter saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt, id_alu_src, id_reg_dst, id_reg_write;
  logic        id_mem_read, id_mem_write, id_mem_to_reg;
  logic [3:0]  id_alu_op;
  logic        flush;

  logic        ex_valid;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_wreg;
  logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [3:0]  ex_alu_op;
  logic        stall;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_valid;
  logic [31:0] s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs, s_rt, s_wreg;
  logic        s_alu_src, s_reg_write, s_mem_read, s_mem_write, s_mem_to_reg;
  logic [3:0]  s_alu_op;
  logic        s_stall;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_op(id_alu_op), .flush(flush),
    .ex_valid(ex_valid), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op),
    .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.CNTW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_op(id_alu_op), .flush(flush),
    .ex_valid(s_valid), .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_wreg(s_wreg),
    .ex_alu_src(s_alu_src), .ex_reg_write(s_reg_write), .ex_mem_read(s_mem_read),
    .ex_mem_write(s_mem_write), .ex_mem_to_reg(s_mem_to_reg), .ex_alu_op(s_alu_op),
    .stall(s_stall), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0;
    id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
    id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    id_alu_op = 0; flush = 0;
  endtask

  // Load word: rt is the destination, rs the base.
  task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
    id_clear();
    id_valid = 1; id_rs = rs; id_rt = rt; id_imm = 32'd4; id_alu_src = 1;
    id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
  endtask

  // R-type ADD reading rs and rt, writing rd.
  task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_clear();
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = 1;
    id_reg_dst = 1; id_reg_write = 1; id_alu_op = 4'd2;
  endtask

  task automatic test_reset();
    set_add(5'd1, 5'd2, 5'd3);
    id_rd1 = 32'hDEAD; id_rd2 = 32'hBEEF; id_imm = 32'h1234;
    rst_n = 0;
    tick();
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h expected 0", ex_valid); end
    checks++; if ({ex_rd1, ex_rd2, ex_imm} !== 96'd0) begin errors++; $display("FAIL reset_data got %0h %0h %0h expected 0", ex_rd1, ex_rd2, ex_imm); end
    checks++; if ({ex_rs, ex_rt, ex_wreg, ex_alu_op} !== 19'd0) begin errors++; $display("FAIL reset_spec got %0h %0h %0h %0h expected 0", ex_rs, ex_rt, ex_wreg, ex_alu_op); end
    checks++; if ({ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 5'd0) begin errors++; $display("FAIL reset_ctrl got %b%b%b%b%b expected 0", ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg); end
    checks++; if ({stall, stall_cnt, flush_cnt} !== 33'd0) begin errors++; $display("FAIL reset_stall_cnt got stall=%0b sc=%0d fc=%0d expected 0", stall, stall_cnt, flush_cnt); end
    rst_n = 1;
    set_add(5'd1, 5'd2, 5'd3);
    id_rd1 = 32'd5; id_rd2 = 32'd7;
    tick();
    checks++; if ({ex_valid, ex_rd1, ex_rd2} !== {1'b1, 32'd5, 32'd7}) begin errors++; $display("FAIL add_after_reset got v=%0b rd1=%0d rd2=%0d expected v=1 rd1=5 rd2=7", ex_valid, ex_rd1, ex_rd2); end
    checks++; if ({ex_wreg, ex_reg_write, ex_alu_op} !== {5'd3, 1'b1, 4'd2}) begin errors++; $display("FAIL add_dest got wreg=%0d rw=%0b op=%0d expected 3 1 2", ex_wreg, ex_reg_write, ex_alu_op); end
    $display("test_reset: ADD rd1=%0d rd2=%0d reached EX", ex_rd1, ex_rd2);
  endtask

  task automatic test_immediate();
    id_clear();
    id_valid = 1; id_imm = 32'hFFFFFFF0; id_alu_src = 1; id_reg_dst = 0;
    id_rs = 5'd2; id_rt = 5'd9; id_rd = 5'd15; id_reg_write = 1; id_alu_op = 4'd2;
    tick();
    checks++; if (ex_imm !== 32'hFFFFFFF0) begin errors++; $display("FAIL addi_imm got %0h expected fffffff0", ex_imm); end
    checks++; if ({ex_alu_src, ex_wreg, ex_reg_write} !== {1'b1, 5'd9, 1'b1}) begin errors++; $display("FAIL addi_ctrl got src=%0b wreg=%0d rw=%0b expected 1 9 1", ex_alu_src, ex_wreg, ex_reg_write); end
    $display("test_immediate: ADDI imm=%0h wreg=%0d", ex_imm, ex_wreg);
  endtask

  task automatic test_load_use_rs();
    set_lw(5'd1, 5'd3);
    tick();
    checks++; if ({ex_mem_read, ex_wreg} !== {1'b1, 5'd3}) begin errors++; $display("FAIL lw_in_ex got mr=%0b wreg=%0d expected 1 3", ex_mem_read, ex_wreg); end
    set_add(5'd3, 5'd5, 5'd6);
    id_rd1 = 32'd11;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_rs_stall got %0b expected 1", stall); end
    tick();
    checks++; if ({ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_op, ex_rd1} !== 41'd0) begin errors++; $display("FAIL lu_rs_bubble got v=%0b rw=%0b mr=%0b op=%0d rd1=%0d expected all 0", ex_valid, ex_reg_write, ex_mem_read, ex_alu_op, ex_rd1); end
    checks++; if ({stall, stall_cnt} !== {1'b0, 16'd1}) begin errors++; $display("FAIL lu_rs_once got stall=%0b sc=%0d expected 0 1", stall, stall_cnt); end
    tick();
    checks++; if ({ex_valid, ex_wreg, ex_rs, ex_rd1} !== {1'b1, 5'd6, 5'd3, 32'd11}) begin errors++; $display("FAIL lu_rs_capture got v=%0b wreg=%0d rs=%0d rd1=%0d expected 1 6 3 11", ex_valid, ex_wreg, ex_rs, ex_rd1); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_rs_cnt got %0d expected 1", stall_cnt); end
    $display("test_load_use_rs: stall_cnt=%0d", stall_cnt);
  endtask

  task automatic test_load_use_edges();
    set_lw(5'd1, 5'd0);
    tick();
    checks++; if ({ex_valid, ex_mem_read, ex_wreg, ex_reg_write} !== {1'b1, 1'b1, 5'd0, 1'b0}) begin errors++; $display("FAIL lw_r0_drop got v=%0b mr=%0b wreg=%0d rw=%0b expected 1 1 0 0", ex_valid, ex_mem_read, ex_wreg, ex_reg_write); end
    set_add(5'd0, 5'd0, 5'd2);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_r0_nostall got %0b expected 0", stall); end
    tick();
    set_lw(5'd1, 5'd4);
    tick();
    set_add(5'd1, 5'd4, 5'd2);
    id_uses_rt = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_rt_unused got %0b expected 0", stall); end
    id_uses_rt = 1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_rt_used got %0b expected 1", stall); end
    tick();
    checks++; if ({ex_valid, stall_cnt} !== {1'b0, 16'd2}) begin errors++; $display("FAIL lu_rt_bubble got v=%0b sc=%0d expected 0 2", ex_valid, stall_cnt); end
    tick();
    checks++; if ({ex_valid, ex_rt} !== {1'b1, 5'd4}) begin errors++; $display("FAIL lu_rt_capture got v=%0b rt=%0d expected 1 4", ex_valid, ex_rt); end
    id_clear();
    tick();
    $display("test_load_use_edges: stall_cnt=%0d", stall_cnt);
  endtask

  task automatic test_flush();
    set_lw(5'd1, 5'd7);
    tick();
    set_add(5'd7, 5'd1, 5'd2);
    flush = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_over_hz got stall=%0b expected 0", stall); end
    tick();
    checks++; if ({ex_valid, ex_reg_write, ex_alu_op} !== 6'd0) begin errors++; $display("FAIL flush_bubble got v=%0b rw=%0b op=%0d expected 0", ex_valid, ex_reg_write, ex_alu_op); end
    checks++; if ({flush_cnt, stall_cnt} !== {16'd1, 16'd2}) begin errors++; $display("FAIL flush_cnts got fc=%0d sc=%0d expected 1 2", flush_cnt, stall_cnt); end
    id_valid = 0;
    tick();
    checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_no_valid got %0d expected 1", flush_cnt); end
    set_add(5'd1, 5'd2, 5'd3);
    flush = 1;
    tick();
    checks++; if ({ex_valid, flush_cnt} !== {1'b0, 16'd2}) begin errors++; $display("FAIL flush_plain got v=%0b fc=%0d expected 0 2", ex_valid, flush_cnt); end
    id_clear();
    tick();
    $display("test_flush: flush_cnt=%0d stall_cnt=%0d", flush_cnt, stall_cnt);
  endtask

  task automatic test_back_to_back();
    set_lw(5'd1, 5'd3);
    tick();
    set_lw(5'd3, 5'd8);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_first_stall got %0b expected 1", stall); end
    tick();
    checks++; if ({ex_valid, stall} !== 2'b00) begin errors++; $display("FAIL b2b_first_bubble got v=%0b stall=%0b expected 0 0", ex_valid, stall); end
    tick();
    checks++; if ({ex_valid, ex_mem_read, ex_wreg, stall_cnt} !== {1'b1, 1'b1, 5'd8, 16'd3}) begin errors++; $display("FAIL b2b_lw2 got v=%0b mr=%0b wreg=%0d sc=%0d expected 1 1 8 3", ex_valid, ex_mem_read, ex_wreg, stall_cnt); end
    set_add(5'd8, 5'd9, 5'd10);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_second_stall got %0b expected 1", stall); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL b2b_second_bubble got %0b expected 0", ex_valid); end
    tick();
    checks++; if ({ex_valid, ex_wreg, stall_cnt} !== {1'b1, 5'd10, 16'd4}) begin errors++; $display("FAIL b2b_add got v=%0b wreg=%0d sc=%0d expected 1 10 4", ex_valid, ex_wreg, stall_cnt); end
    id_clear();
    tick();
    $display("test_back_to_back: stall_cnt=%0d", stall_cnt);
  endtask

  // A self-dependent load held in ID stalls on every other cycle: 20 stalls in 40.
  task automatic test_saturation();
    set_lw(5'd3, 5'd3);
    for (int i = 0; i < 40; i++) tick();
    checks++; if (stall_cnt !== 16'd24) begin errors++; $display("FAIL sat_wide got %0d expected 24", stall_cnt); end
    checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_narrow got %0d expected 15", s_stall_cnt); end
    checks++; if (s_flush_cnt !== 4'd2) begin errors++; $display("FAIL sat_narrow_flush got %0d expected 2", s_flush_cnt); end
    id_clear();
    tick();
    $display("test_saturation: wide=%0d narrow=%0d", stall_cnt, s_stall_cnt);
  endtask

  task automatic test_reset_precedence();
    set_lw(5'd1, 5'd3);
    tick();
    set_add(5'd3, 5'd4, 5'd5);
    id_rd1 = 32'd99;
    flush = 1;
    rst_n = 0;
    tick();
    checks++; if ({ex_valid, ex_rd1, ex_wreg} !== 38'd0) begin errors++; $display("FAIL rst_prec_ex got v=%0b rd1=%0d wreg=%0d expected 0", ex_valid, ex_rd1, ex_wreg); end
    checks++; if ({stall, stall_cnt, flush_cnt, s_stall_cnt} !== 37'd0) begin errors++; $display("FAIL rst_prec_cnt got stall=%0b sc=%0d fc=%0d ssc=%0d expected 0", stall, stall_cnt, flush_cnt, s_stall_cnt); end
    rst_n = 1;
    id_clear();
    tick();
    $display("test_reset_precedence: counters cleared");
  endtask

  initial begin
    id_clear();
    rst_n = 0;
    test_reset();
    test_immediate();
    test_load_use_rs();
    test_load_use_edges();
    test_flush();
    test_back_to_back();
    test_saturation();
    test_reset_precedence();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
